// File: rtl/seven_seg_scan_driver_if.sv
// Handshake and status bundle between a datapath and the seven-segment driver.
//   IN       : unsigned binary value to show (IN_WIDTH bits)
//   LOAD     : request a conversion of IN
//   DP_MASK  : per-digit decimal point enables, digit 0 least significant
//   BUSY     : conversion in progress
//   DONE     : one-cycle pulse when a new value is committed to the display
//   OVF      : committed value does not fit in DIGITS decimal digits
// The master modport is the requester and the slave modport is the driver.
interface seven_seg_scan_driver_if #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3
);
  logic [IN_WIDTH-1:0] IN;
  logic                LOAD;
  logic [DIGITS-1:0]   DP_MASK;
  logic                BUSY;
  logic                DONE;
  logic                OVF;

  modport master (output IN, LOAD, DP_MASK, input BUSY, DONE, OVF);
  modport slave  (input IN, LOAD, DP_MASK, output BUSY, DONE, OVF);
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Multi-digit common-anode seven-segment driver.
// A binary value is converted to BCD by a shift-add-3 engine (one bit per
// clock) and committed atomically to the display register. The digits are
// then time-multiplexed, each enabled for REFRESH_DIV clocks.
// Ports:
//   CLK_12MHz          : system clock, rising edge
//   RST_n              : asynchronous active-low reset
//   bus                : IN/LOAD/DP_MASK request side, BUSY/DONE/OVF status side
//   SevenSegment       : active-low segments, bit7 = DP, bits6:0 = g..a
//   SevenSegmentEnable : active-low one-hot digit anodes
module seven_seg_scan_driver #(
  parameter int IN_WIDTH    = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 12000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  CLK_12MHz,
  input  logic                  RST_n,
  seven_seg_scan_driver_if.slave bus,
  output logic [7:0]            SevenSegment,
  output logic [DIGITS-1:0]     SevenSegmentEnable
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = IN_WIDTH + BCD_W;
  localparam int CNT_W  = $clog2(IN_WIDTH + 1);
  localparam int PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(IN_WIDTH);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef enum logic {S_IDLE, S_CONVERT} state_t;

  state_t              state;
  logic [WORK_W-1:0]   work;
  logic [CNT_W-1:0]    bit_cnt;
  logic                ovf_pend;
  logic [BCD_W-1:0]    disp_bcd;
  logic                busy;
  logic                done;
  logic                ovf;
  logic [31:0]         in_wide;

  logic [PRE_W-1:0]    pre;
  logic [IDX_W-1:0]    idx;

  logic [3:0]          nibble;
  logic                sel_zero;
  logic                dp_bit;
  logic [DIGITS-1:0]   upper_zero;
  logic [DIGITS-1:0]   en_onehot;
  logic [6:0]          seg_bits;

  assign bus.BUSY = busy;
  assign bus.DONE = done;
  assign bus.OVF  = ovf;
  assign in_wide  = 32'(bus.IN);

  // One double-dabble step: bias every BCD nibble of 5 or more by 3 so the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [WORK_W-1:0] adjust_shift(input logic [WORK_W-1:0] w);
    logic [WORK_W-1:0] r;
    r = w;
    for (int k = 0; k < DIGITS; k++) begin
      if (r[IN_WIDTH + 4*k +: 4] >= 4'd5)
        r[IN_WIDTH + 4*k +: 4] = r[IN_WIDTH + 4*k +: 4] + 4'd3;
    end
    return {r[WORK_W-2:0], 1'b0};
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h18;
      default: return 7'h7F;
    endcase
  endfunction

  // Conversion FSM. The overflow verdict is taken at capture time and held
  // with the working register so that the display value and OVF change on
  // the same commit edge; LOAD is only honoured while idle.
  always_ff @(posedge CLK_12MHz or negedge RST_n) begin
    if (!RST_n) begin
      state    <= S_IDLE;
      work     <= '0;
      bit_cnt  <= '0;
      ovf_pend <= 1'b0;
      disp_bcd <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.LOAD) begin
            work     <= {{BCD_W{1'b0}}, bus.IN};
            bit_cnt  <= '0;
            ovf_pend <= (in_wide > MAX_VAL);
            busy     <= 1'b1;
            state    <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          if (bit_cnt == LAST_BIT) begin
            disp_bcd <= work[WORK_W-1 -: BCD_W];
            ovf      <= ovf_pend;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            work    <= adjust_shift(work);
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Refresh prescaler and digit index.
  always_ff @(posedge CLK_12MHz or negedge RST_n) begin
    if (!RST_n) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // upper_zero[k] means digit k and every more-significant digit are zero,
  // which is exactly the leading-zero blanking condition for digit k.
  always_comb begin
    upper_zero = '0;
    upper_zero[DIGITS-1] = (disp_bcd[BCD_W-1 -: 4] == 4'd0);
    for (int k = DIGITS - 2; k >= 0; k--)
      upper_zero[k] = (disp_bcd[4*k +: 4] == 4'd0) && upper_zero[k+1];

    nibble    = 4'd0;
    sel_zero  = 1'b0;
    dp_bit    = 1'b0;
    en_onehot = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        nibble       = disp_bcd[4*k +: 4];
        sel_zero     = upper_zero[k];
        dp_bit       = bus.DP_MASK[k];
        en_onehot[k] = 1'b1;
      end
    end

    if (ovf)
      seg_bits = 7'b0111111;
    else if ((BLANK_LZ != 0) && (idx != '0) && sel_zero)
      seg_bits = 7'h7F;
    else
      seg_bits = decode(nibble);
  end

  // Registered pin drivers, one cycle behind the index and display data.
  always_ff @(posedge CLK_12MHz or negedge RST_n) begin
    if (!RST_n) begin
      SevenSegment       <= 8'hFF;
      SevenSegmentEnable <= '1;
    end else begin
      SevenSegment       <= {~dp_bit, seg_bits};
      SevenSegmentEnable <= ~en_onehot;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver.
// Two instances share one request stream:
//   dut_a : 8-bit input, 3 digits, leading-zero blanking, 4-cycle refresh
//   dut_b : 8-bit input, 2 digits, no blanking, 3-cycle refresh (overflow cases)
// The stimulus process pushes hand-computed expectations into per-instance
// queues; monitor processes pop an entry on every DONE pulse and check the
// latency, OVF, DONE width and one full scan of the display.
module tb_seven_seg_scan_driver;

  // Expected response of one committed conversion.
  typedef struct packed {
    int               load_cyc;
    logic             ovf;
    logic [5:0][7:0]  seg;
    logic             scan;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] seg_a;
  logic [2:0] en_a;
  logic [7:0] seg_b;
  logic [1:0] en_b;

  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  seven_seg_scan_driver_if #(.IN_WIDTH(8), .DIGITS(3)) bus_a ();
  seven_seg_scan_driver_if #(.IN_WIDTH(8), .DIGITS(2)) bus_b ();

  seven_seg_scan_driver #(
    .IN_WIDTH(8), .DIGITS(3), .REFRESH_DIV(4), .BLANK_LZ(1)
  ) dut_a (
    .CLK_12MHz(clk), .RST_n(rst_n), .bus(bus_a),
    .SevenSegment(seg_a), .SevenSegmentEnable(en_a)
  );

  seven_seg_scan_driver #(
    .IN_WIDTH(8), .DIGITS(2), .REFRESH_DIV(3), .BLANK_LZ(0)
  ) dut_b (
    .CLK_12MHz(clk), .RST_n(rst_n), .bus(bus_b),
    .SevenSegment(seg_b), .SevenSegmentEnable(en_b)
  );

  always #5 clk = ~clk;

  // Rising-edge counter used to measure request-to-DONE latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic reportFail(input string name, input logic [31:0] actual);
    n_vec++;
    n_err++;
    $display("[TB] FAIL %s: got %0h (t=%0t)", name, actual, $time);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_seg_a"},  32'(seg_a), 32'hFF);
    checkOutput({tag, "_en_a"},   32'(en_a), 32'h7);
    checkOutput({tag, "_busy_a"}, 32'(bus_a.BUSY), 32'h0);
    checkOutput({tag, "_done_a"}, 32'(bus_a.DONE), 32'h0);
    checkOutput({tag, "_ovf_a"},  32'(bus_a.OVF), 32'h0);
    checkOutput({tag, "_seg_b"},  32'(seg_b), 32'hFF);
    checkOutput({tag, "_en_b"},   32'(en_b), 32'h3);
    checkOutput({tag, "_busy_b"}, 32'(bus_b.BUSY), 32'h0);
    checkOutput({tag, "_ovf_b"},  32'(bus_b.OVF), 32'h0);
  endtask

  // Issue one LOAD to both instances and queue the expected results.
  // segs_a = {digit2, digit1, digit0}, segs_b = {digit1, digit0}.
  // ignored_in >= 0 adds a second LOAD pulse while BUSY, which must be dropped.
  task automatic applyStimulus(input int in_val, input logic [2:0] dp_a,
                               input logic [1:0] dp_b, input logic ovf_a,
                               input logic [23:0] segs_a, input logic ovf_b,
                               input logic [15:0] segs_b, input int ignored_in);
    exp_t e;
    bus_a.IN      = in_val[7:0];
    bus_b.IN      = in_val[7:0];
    bus_a.DP_MASK = dp_a;
    bus_b.DP_MASK = dp_b;
    bus_a.LOAD    = 1'b1;
    bus_b.LOAD    = 1'b1;
    e          = '0;
    e.load_cyc = cyc + 1;
    e.ovf      = ovf_a;
    e.seg[0]   = segs_a[7:0];
    e.seg[1]   = segs_a[15:8];
    e.seg[2]   = segs_a[23:16];
    e.scan     = 1'b1;
    q_a.push_back(e);
    e.ovf      = ovf_b;
    e.seg[0]   = segs_b[7:0];
    e.seg[1]   = segs_b[15:8];
    e.seg[2]   = 8'h00;
    q_b.push_back(e);
    @(negedge clk);
    bus_a.LOAD = 1'b0;
    bus_b.LOAD = 1'b0;
    checkOutput($sformatf("busy_a_%0d", in_val), 32'(bus_a.BUSY), 32'h1);
    checkOutput($sformatf("busy_b_%0d", in_val), 32'(bus_b.BUSY), 32'h1);
    if (ignored_in >= 0) begin
      repeat (3) @(negedge clk);
      bus_a.IN   = ignored_in[7:0];
      bus_b.IN   = ignored_in[7:0];
      bus_a.LOAD = 1'b1;
      bus_b.LOAD = 1'b1;
      @(negedge clk);
      bus_a.LOAD = 1'b0;
      bus_b.LOAD = 1'b0;
    end
    repeat (30) @(negedge clk);
  endtask

  // Monitor for dut_a: 3 digits x 4 cycles per full scan.
  initial begin : mon_a
    exp_t e;
    int   idx;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus_a.DONE === 1'b1) begin
        if (q_a.size() == 0) begin
          reportFail("a_unexpected_done", 32'(bus_a.DONE));
        end else begin
          e = q_a.pop_front();
          checkOutput("a_latency", 32'(cyc - e.load_cyc), 32'd9);
          checkOutput("a_ovf", 32'(bus_a.OVF), 32'(e.ovf));
          @(negedge clk);
          checkOutput("a_done_width", 32'(bus_a.DONE), 32'h0);
          if (e.scan) begin
            for (int s = 0; s < 12; s++) begin
              idx = -1;
              for (int k = 0; k < 3; k++)
                if (en_a == ~(3'b001 << k)) idx = k;
              if (idx < 0)
                reportFail("a_enable_onehot", 32'(en_a));
              else
                checkOutput($sformatf("a_seg_d%0d", idx), 32'(seg_a), 32'(e.seg[idx]));
              @(negedge clk);
            end
          end
        end
      end
    end
  end

  // Monitor for dut_b: 2 digits x 3 cycles per full scan.
  initial begin : mon_b
    exp_t e;
    int   idx;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus_b.DONE === 1'b1) begin
        if (q_b.size() == 0) begin
          reportFail("b_unexpected_done", 32'(bus_b.DONE));
        end else begin
          e = q_b.pop_front();
          checkOutput("b_latency", 32'(cyc - e.load_cyc), 32'd9);
          checkOutput("b_ovf", 32'(bus_b.OVF), 32'(e.ovf));
          @(negedge clk);
          checkOutput("b_done_width", 32'(bus_b.DONE), 32'h0);
          if (e.scan) begin
            for (int s = 0; s < 6; s++) begin
              idx = -1;
              for (int k = 0; k < 2; k++)
                if (en_b == ~(2'b01 << k)) idx = k;
              if (idx < 0)
                reportFail("b_enable_onehot", 32'(en_b));
              else
                checkOutput($sformatf("b_seg_d%0d", idx), 32'(seg_b), 32'(e.seg[idx]));
              @(negedge clk);
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    exp_t e;
    int   base;
    rst_n         = 1'b0;
    bus_a.IN      = '0;
    bus_a.LOAD    = 1'b0;
    bus_a.DP_MASK = '0;
    bus_b.IN      = '0;
    bus_b.LOAD    = 1'b0;
    bus_b.DP_MASK = '0;
    repeat (2) @(negedge clk);
    checkResetState("por");
    rst_n = 1'b1;
    @(negedge clk);

    // 123: three distinct digits on A; does not fit two digits on B.
    applyStimulus(123, 3'b000, 2'b00, 1'b0, 24'hF9_A4_B0, 1'b1, 16'hBF_BF, -1);

    // Reset in the middle of a conversion of 200: abort, clear display and OVF.
    $display("[TB] reset during conversion");
    bus_a.IN   = 8'd200;
    bus_b.IN   = 8'd200;
    bus_a.LOAD = 1'b1;
    bus_b.LOAD = 1'b1;
    @(negedge clk);
    bus_a.LOAD = 1'b0;
    bus_b.LOAD = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetState("mid_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_en_a", 32'(en_a), 32'h6);
    checkOutput("post_rst_seg_a", 32'(seg_a), 32'hC0);
    checkOutput("post_rst_en_b", 32'(en_b), 32'h2);
    checkOutput("post_rst_seg_b", 32'(seg_b), 32'hC0);
    repeat (20) @(negedge clk);

    // Blanking versus plain display of small values.
    applyStimulus(7,   3'b000, 2'b00, 1'b0, 24'hFF_FF_F8, 1'b0, 16'hC0_F8, -1);
    applyStimulus(0,   3'b000, 2'b00, 1'b0, 24'hFF_FF_C0, 1'b0, 16'hC0_C0, -1);
    applyStimulus(255, 3'b000, 2'b00, 1'b0, 24'hA4_92_92, 1'b1, 16'hBF_BF, -1);
    // 42 with an extra LOAD of 9 while busy, which must not be taken.
    applyStimulus(42,  3'b000, 2'b00, 1'b0, 24'hFF_99_A4, 1'b0, 16'h99_A4, 9);
    // Decimal points: lit on a blanked digit of A and on an unblanked zero of B.
    applyStimulus(5,   3'b010, 2'b10, 1'b0, 24'hFF_7F_92, 1'b0, 16'h40_92, -1);
    // Overflow boundaries for the two-digit instance.
    applyStimulus(99,  3'b000, 2'b00, 1'b0, 24'hFF_98_98, 1'b0, 16'h98_98, -1);
    applyStimulus(100, 3'b000, 2'b00, 1'b0, 24'hF9_C0_C0, 1'b1, 16'hBF_BF, -1);

    // LOAD held high: captures every 10 cycles, DONE every 10 cycles.
    $display("[TB] back-to-back conversions of 255");
    bus_a.IN      = 8'd255;
    bus_b.IN      = 8'd255;
    bus_a.DP_MASK = '0;
    bus_b.DP_MASK = '0;
    bus_a.LOAD    = 1'b1;
    bus_b.LOAD    = 1'b1;
    base = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      e          = '0;
      e.load_cyc = base + 10 * k;
      e.scan     = (k == 2);
      e.ovf      = 1'b0;
      e.seg[0]   = 8'h92;
      e.seg[1]   = 8'h92;
      e.seg[2]   = 8'hA4;
      q_a.push_back(e);
      e.ovf      = 1'b1;
      e.seg[0]   = 8'hBF;
      e.seg[1]   = 8'hBF;
      e.seg[2]   = 8'h00;
      q_b.push_back(e);
    end
    repeat (21) @(negedge clk);
    bus_a.LOAD = 1'b0;
    bus_b.LOAD = 1'b0;
    repeat (35) @(negedge clk);

    // Any expectation still queued means its DONE never arrived.
    checkOutput("pending_a", 32'(q_a.size()), 32'h0);
    checkOutput("pending_b", 32'(q_b.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
